// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused LSB-first over WIDTH
// cycles, with a carry flop closing the ripple loop between bit steps.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_shifted;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
    full_adder = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign {fa_co, fa_s} = full_adder(a_sh[0], b_sh[0], carry);
  assign last_bit      = (cnt == LAST);

  // New sum bits enter at the MSB so that after WIDTH steps bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shifted = fa_s;
    end else begin : g_wn
      assign sum_shifted = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_shifted;
          carry  <= fa_co;
          // On the MSB step the carry flop holds exactly the carry into the MSB.
          if (last_bit) begin
            sum      <= sum_shifted;
            c_out    <= fa_co;
            overflow <= carry ^ fa_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv[2];
  logic       ordy[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       cv[2];

  logic       ir8, ovd8, bs8, co8, of8;
  logic [7:0] sm8;
  logic       ir1, ovd1, bs1, co1, of1;
  logic [0:0] sm1;

  int checks   = 0;
  int failures = 0;

  // model state
  logic       m_busy[2];
  logic       m_done[2];
  int         m_left[2];
  logic [7:0] m_sum[2];
  logic       m_co[2];
  logic       m_ov[2];
  logic [7:0] p_sum[2];
  logic       p_co[2];
  logic       p_ov[2];
  int         m_acc[2];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8),
    .a(av[0]), .b(bv[0]), .c_in(cv[0]), .out_valid(ovd8), .out_ready(ordy[0]),
    .sum(sm8), .c_out(co8), .overflow(of8), .busy(bs8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .a(av[1][0:0]), .b(bv[1][0:0]), .c_in(cv[1]), .out_valid(ovd1), .out_ready(ordy[1]),
    .sum(sm1), .c_out(co1), .overflow(of1), .busy(bs1)
  );

  // Transaction model: an accepted operation reports its arithmetic result
  // exactly w edges later and is retired by out_ready.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      int w, mask, ma, mb, full, s;
      w    = (i == 0) ? 8 : 1;
      mask = (1 << w) - 1;
      ma   = int'(av[i]) & mask;
      mb   = int'(bv[i]) & mask;
      full = ma + mb + int'(cv[i]);
      s    = full & mask;
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_left[i] <= 0;
        m_sum[i]  <= 8'd0;
        m_co[i]   <= 1'b0;
        m_ov[i]   <= 1'b0;
      end else if (!m_busy[i]) begin
        if (iv[i]) begin
          m_busy[i] <= 1'b1;
          m_left[i] <= w;
          p_sum[i]  <= 8'(s);
          p_co[i]   <= ((full >> w) & 1) != 0;
          p_ov[i]   <= (((ma >> (w-1)) & 1) == ((mb >> (w-1)) & 1)) &&
                       (((s >> (w-1)) & 1) != ((ma >> (w-1)) & 1));
          m_acc[i]  <= m_acc[i] + 1;
        end
      end else if (m_left[i] > 0) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_done[i] <= 1'b1;
          m_sum[i]  <= p_sum[i];
          m_co[i]   <= p_co[i];
          m_ov[i]   <= p_ov[i];
        end
      end else if (ordy[i]) begin
        m_done[i] <= 1'b0;
        m_busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic [12:0] act_vec(int i);
    if (i == 0) return {ir8, ovd8, bs8, co8, of8, sm8};
    return {ir1, ovd1, bs1, co1, of1, 7'd0, sm1};
  endfunction

  function automatic logic [12:0] exp_vec(int i);
    return {~m_busy[i], m_done[i], m_busy[i], m_co[i], m_ov[i], m_sum[i]};
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL cycle_cmp dut%0d t=%0t {in_ready,out_valid,busy,c_out,ovf,sum} got %b want %b",
                 i, $time, act_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic chk(input string nm, input int actv, input int expv);
    checks++;
    if (actv != expv) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, actv, expv);
    end
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!ovd8 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic op8(input string nm, input int ai, input int bi, input int ci,
                     input int es, input int eco, input int eov);
    int n;
    chk({nm, "_ready_before"}, int'(ir8), 1);
    av[0] = 8'(ai); bv[0] = 8'(bi); cv[0] = 1'(ci); iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    wait_valid8(n);
    chk({nm, "_latency"}, n, 8);
    chk({nm, "_sum"}, int'(sm8), es);
    chk({nm, "_cout"}, int'(co8), eco);
    chk({nm, "_ovf"}, int'(of8), eov);
    tick();
    chk({nm, "_ready_after"}, int'(ir8), 1);
  endtask

  initial begin
    int n, base0, base1, cyc;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; av[i] = 8'd0; bv[i] = 8'd0; cv[i] = 1'b0; m_acc[i] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", int'(ir8), 1);
    chk("reset_out_valid", int'(ovd8), 0);
    chk("reset_busy", int'(bs8), 0);
    chk("reset_sum", int'(sm8), 0);
    rst_n = 1'b1;
    tick();

    op8("add_100_27", 100, 27, 0, 127, 0, 0);
    op8("add_255_1", 255, 1, 0, 0, 1, 0);
    op8("add_0_0_c1", 0, 0, 1, 1, 0, 0);
    op8("add_127_1", 127, 1, 0, 128, 0, 1);
    op8("add_128_128", 128, 128, 0, 0, 1, 1);

    // backpressure with new operands offered throughout DONE
    ordy[0] = 1'b0;
    av[0] = 8'd200; bv[0] = 8'd100; cv[0] = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    wait_valid8(n);
    chk("bp_latency", n, 8);
    for (int k = 0; k < 5; k++) begin
      av[0] = 8'd1; bv[0] = 8'd1; iv[0] = 1'b1;
      tick();
      chk("bp_sum", int'(sm8), 44);
      chk("bp_cout", int'(co8), 1);
      chk("bp_in_ready", int'(ir8), 0);
      chk("bp_busy", int'(bs8), 1);
      chk("bp_out_valid", int'(ovd8), 1);
    end
    ordy[0] = 1'b1;
    tick();
    chk("bp_release_valid", int'(ovd8), 0);
    chk("bp_release_ready", int'(ir8), 1);
    chk("bp_sum_held", int'(sm8), 44);
    iv[0] = 1'b0;
    tick();
    chk("bp_no_capture", int'(bs8), 0);

    // asynchronous reset while cnt==4
    av[0] = 8'd77; bv[0] = 8'd88; cv[0] = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", int'(sm8), 0);
    chk("arst_cout", int'(co8), 0);
    chk("arst_out_valid", int'(ovd8), 0);
    chk("arst_in_ready", int'(ir8), 1);
    tick();
    #1 rst_n = 1'b1;
    op8("add_200_55", 200, 55, 0, 255, 0, 0);

    // random sweep on both widths
    base0 = m_acc[0];
    base1 = m_acc[1];
    cyc = 0;
    while ((m_acc[0] - base0 < 500 || m_acc[1] - base1 < 500) && cyc < 30000) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = 1'($urandom_range(0, 1));
        av[i]   = 8'($urandom);
        bv[i]   = 8'($urandom);
        cv[i]   = 1'($urandom_range(0, 1));
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
      cyc++;
    end
    chk("sweep_ops_w8", int'(m_acc[0] - base0 >= 500), 1);
    chk("sweep_ops_w1", int'(m_acc[1] - base1 >= 500), 1);
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (12) tick();
    chk("drain_idle_w8", int'(ir8), 1);
    chk("drain_idle_w1", int'(ir1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
